// File: rtl/ps_pwm_modulator_if.sv
// ---------------------------------------------------------------------------
// ps_pwm_modulator_if
// Bundle between the control loop and the phase-shifted PWM modulator.
//   en    : modulator enable (0 forces all gates off)
//   mod   : signed modulation reference, W bits
//   gate  : 4 gate drives per cell, cell k at [4k+3:4k] = {B-low, B-high, A-low, A-high}
//   sync  : 1-cycle pulse at the cell-0 carrier peak
// master = control side (drives en/mod), slave = modulator (drives gate/sync).
// ---------------------------------------------------------------------------
interface ps_pwm_modulator_if #(
    parameter int W       = 8,
    parameter int N_CELLS = 3
);
    logic                   en;
    logic signed [W-1:0]    mod;
    logic [4*N_CELLS-1:0]   gate;
    logic                   sync;

    modport master (output en, output mod, input gate, input sync);
    modport slave  (input en, input mod, output gate, output sync);
endinterface

// File: rtl/ps_pwm_modulator.sv
// ---------------------------------------------------------------------------
// ps_pwm_modulator
// Phase-shifted PWM modulator for a cascaded H-bridge active filter.
// A phase accumulator p (0..4*CMAX-1) produces N_CELLS triangular carriers
// spaced P/(2*N_CELLS) apart. Each cell compares +mod_q (leg A) and -mod_q
// (leg B) against its carrier; each leg then passes through a dead-time
// stage driving its high/low switch.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-high (overrides en)
//   bus  : slave modport of ps_pwm_modulator_if (en, mod in; gate, sync out)
// ---------------------------------------------------------------------------
module ps_pwm_modulator #(
    parameter int W        = 8,
    parameter int N_CELLS  = 3,
    parameter int CMAX     = 120,
    parameter int DT       = 4,
    parameter int UPD_MODE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    ps_pwm_modulator_if.slave      bus
);
    localparam int P    = 4 * CMAX;
    localparam int STEP = P / (2 * N_CELLS);
    localparam int PW   = $clog2(P);
    // Signed width wide enough for carrier values and for -mod without overflow.
    localparam int XW   = (((PW + 2) > (W + 1)) ? (PW + 2) : (W + 1)) + 1;
    localparam int NL   = 2 * N_CELLS;
    localparam int CW   = (DT > 0) ? $clog2(DT + 1) : 1;
    localparam logic [CW-1:0] DT_C  = CW'(DT);
    localparam logic [CW-1:0] DT_M1 = (DT > 0) ? CW'(DT - 1) : '0;

    generate
        if ((P % (2 * N_CELLS)) != 0 || N_CELLS < 1 || N_CELLS > 8 ||
            CMAX > (2 ** (W - 1)) - 1) begin : g_bad_cfg
            $error("ps_pwm_modulator: 4*CMAX must be divisible by 2*N_CELLS, N_CELLS in 1..8, CMAX <= 2^(W-1)-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        LEG_OFF = 2'b00,
        LEG_UP  = 2'b01,
        LEG_DN  = 2'b10
    } leg_state_e;

    logic [PW-1:0]          p_q, p_d;
    logic signed [W-1:0]    mod_q, mod_d;
    logic [NL-1:0]          req_q, req_d;     // leg requests: [2k]=A, [2k+1]=B
    logic [NL-1:0]          seen_q, seen_d;   // request seen by the dead-time stage
    leg_state_e             state_q [NL];
    leg_state_e             state_d [NL];
    logic [CW-1:0]          cnt_q [NL];
    logic [CW-1:0]          cnt_d [NL];
    logic [4*N_CELLS-1:0]   gate_q, gate_d;
    logic                   sync_q, sync_d;

    // Phase, reference latch, sync and carrier compare.
    logic [PW:0]            pk;
    logic signed [XW-1:0]   pk_x, ck, mod_x, neg_x;

    always_comb begin
        p_d = p_q;
        if (bus.en) begin
            p_d = (p_q == PW'(P - 1)) ? '0 : p_q + PW'(1);
        end

        mod_d = mod_q;
        if (bus.en && ((p_q == '0) || ((UPD_MODE == 1) && (p_q == PW'(2 * CMAX))))) begin
            mod_d = bus.mod;
        end

        sync_d = bus.en && (p_q == '0);

        mod_x = XW'(mod_q);
        neg_x = -mod_x;
        pk    = '0;
        pk_x  = '0;
        ck    = '0;
        req_d = '0;
        for (int unsigned k = 0; k < N_CELLS; k++) begin
            pk = {1'b0, p_q} + (PW + 1)'(k * STEP);
            if (pk >= (PW + 1)'(P)) begin
                pk = pk - (PW + 1)'(P);
            end
            pk_x = $signed(XW'(pk));
            if (pk < (PW + 1)'(2 * CMAX)) begin
                ck = XW'(CMAX) - pk_x;
            end else begin
                ck = pk_x - XW'(3 * CMAX);
            end
            req_d[2*k]   = (ck <= mod_x);
            req_d[2*k+1] = (ck <= neg_x);
        end
    end

    // Dead-time stage. The edge that turns a switch off counts as the first
    // dead cycle, so a request change reloads DT-1; disable preloads DT so the
    // switch stays off DT full cycles after en returns.
    leg_state_e want;

    always_comb begin
        want   = LEG_OFF;
        seen_d = req_q;
        gate_d = '0;
        for (int unsigned l = 0; l < NL; l++) begin
            state_d[l] = state_q[l];
            cnt_d[l]   = cnt_q[l];
            want       = req_q[l] ? LEG_UP : LEG_DN;
            if (!bus.en) begin
                state_d[l] = LEG_OFF;
                cnt_d[l]   = DT_C;
            end else if (DT == 0) begin
                state_d[l] = want;
            end else if (state_q[l] != LEG_OFF) begin
                if (state_q[l] != want) begin
                    state_d[l] = LEG_OFF;
                    cnt_d[l]   = DT_M1;
                end
            end else if (req_q[l] != seen_q[l]) begin
                cnt_d[l] = DT_M1;   // request moved again during dead time
            end else if (cnt_q[l] == '0) begin
                state_d[l] = want;
            end else begin
                cnt_d[l] = cnt_q[l] - CW'(1);
            end
            gate_d[2*l]   = (state_d[l] == LEG_UP);
            gate_d[2*l+1] = (state_d[l] == LEG_DN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q    <= '0;
            mod_q  <= '0;
            req_q  <= '0;
            seen_q <= '0;
            gate_q <= '0;
            sync_q <= 1'b0;
            for (int unsigned l = 0; l < NL; l++) begin
                state_q[l] <= LEG_OFF;
                cnt_q[l]   <= DT_C;
            end
        end else begin
            p_q    <= p_d;
            mod_q  <= mod_d;
            req_q  <= req_d;
            seen_q <= seen_d;
            gate_q <= gate_d;
            sync_q <= sync_d;
            for (int unsigned l = 0; l < NL; l++) begin
                state_q[l] <= state_d[l];
                cnt_q[l]   <= cnt_d[l];
            end
        end
    end

    assign bus.gate = gate_q;
    assign bus.sync = sync_q;

endmodule

// File: tb/tb_ps_pwm_modulator.sv
// ---------------------------------------------------------------------------
// tb_ps_pwm_modulator
// dut_a: N_CELLS=3, DT=4, UPD_MODE=1 (reset, phase shift, dead time, enable)
// dut_b: N_CELLS=1, DT=0, UPD_MODE=0 and dut_c: same with UPD_MODE=1, driven
// in lockstep (duty table, reference update timing).
// ---------------------------------------------------------------------------
module tb_ps_pwm_modulator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_bc;

    ps_pwm_modulator_if #(.W(8), .N_CELLS(3)) aif ();
    ps_pwm_modulator_if #(.W(8), .N_CELLS(1)) bif ();
    ps_pwm_modulator_if #(.W(8), .N_CELLS(1)) cif ();

    ps_pwm_modulator #(.W(8), .N_CELLS(3), .CMAX(120), .DT(4), .UPD_MODE(1)) dut_a (
        .clk(clk), .rst(rst_a), .bus(aif));
    ps_pwm_modulator #(.W(8), .N_CELLS(1), .CMAX(120), .DT(0), .UPD_MODE(0)) dut_b (
        .clk(clk), .rst(rst_bc), .bus(bif));
    ps_pwm_modulator #(.W(8), .N_CELLS(1), .CMAX(120), .DT(0), .UPD_MODE(1)) dut_c (
        .clk(clk), .rst(rst_bc), .bus(cif));

    typedef struct {
        logic signed [7:0] mod;
        int                exp_a;   // tr0 high cycles per period
        int                exp_b;   // tr2 high cycles per period
    } vec_t;

    vec_t        tbl [8];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] hist [1000];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_sync_a(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!aif.sync && n < 1000);
        if (!aif.sync) begin
            n_tests++;
            n_fail++;
            $display("FAIL sync_a_timeout: got no pulse in %0d cycles, expected a pulse", n);
        end
    endtask

    task automatic wait_sync_b(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bif.sync && n < 1000);
        if (!bif.sync) begin
            n_tests++;
            n_fail++;
            $display("FAIL sync_b_timeout: got no pulse in %0d cycles, expected a pulse", n);
        end
    endtask

    task automatic set_bc(input logic signed [7:0] m);
        bif.mod = m;
        cif.mod = m;
    endtask

    task automatic record_a();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            hist[i] = aif.gate;
        end
    endtask

    initial begin
        int n, bad, bad2, runs, start, j;
        int ca, cb, cc, cd, nc;

        // Counts over one period for N_CELLS=1, DT=0: carrier takes +-120 once
        // and every value in -119..119 twice, so count(ck<=m) = 2m+241.
        tbl[0] = '{8'sd0,    241, 241};
        tbl[1] = '{8'sd50,   341, 141};
        tbl[2] = '{-8'sd30,  181, 301};
        tbl[3] = '{8'sd120,  480, 1};
        tbl[4] = '{8'sd127,  480, 0};
        tbl[5] = '{8'sh80,   0,   480};
        tbl[6] = '{-8'sd121, 0,   480};
        tbl[7] = '{8'sd119,  479, 3};

        rst_a  = 1'b1;
        rst_bc = 1'b1;
        aif.en = 1'b1; aif.mod = '0;
        bif.en = 1'b1; bif.mod = '0;
        cif.en = 1'b1; cif.mod = '0;
        repeat (3) @(negedge clk);
        rst_a  = 1'b0;
        rst_bc = 1'b0;

        // Reset mid-run.
        aif.mod = 8'sd40;
        repeat (200) @(negedge clk);
        rst_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_gate_%0d", i), int'(aif.gate), 0);
            check($sformatf("rst_sync_%0d", i), int'(aif.sync), 0);
        end
        rst_a = 1'b0;
        @(negedge clk);
        check("first_sync_after_rst", int'(aif.sync), 1);
        wait_sync_a(n);
        check("sync_period", n, 480);

        // Phase shift between cells: cell k leads cell 0 by 80*k cycles.
        aif.mod = 8'sd50;
        wait_sync_a(n);
        wait_sync_a(n);
        record_a();
        bad = 0;
        bad2 = 0;
        for (int t = 0; t < 1000 - 160; t++) begin
            if (hist[t][7:4] != hist[t+80][3:0]) bad++;
            if (hist[t][11:8] != hist[t+160][3:0]) bad2++;
        end
        check("cell1_shift80_mismatches", bad, 0);
        check("cell2_shift160_mismatches", bad2, 0);

        // Dead time: every leg gap is exactly 4 cycles; no shoot-through.
        aif.mod = 8'sd30;
        wait_sync_a(n);
        wait_sync_a(n);
        record_a();
        runs = 0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < 3; k++) begin
                if ((hist[i][4*k] && hist[i][4*k+1]) || (hist[i][4*k+2] && hist[i][4*k+3])) bad++;
            end
        end
        check("shoot_through_cycles", bad, 0);
        for (int l = 0; l < 6; l++) begin
            int i;
            i = 1;
            while (i < 1000) begin
                if (hist[i][2*l +: 2] == 2'b00 && hist[i-1][2*l +: 2] != 2'b00) begin
                    start = i;
                    j = i;
                    while (j < 1000 && hist[j][2*l +: 2] == 2'b00) j++;
                    if (j < 1000) begin
                        check($sformatf("dt_len_leg%0d_at%0d", l, start), j - start, 4);
                        runs++;
                    end
                    i = j;
                end else begin
                    i++;
                end
            end
        end
        check("dt_gaps_seen_ge12", (runs >= 12) ? 1 : 0, 1);

        // Enable drop at p=130 with the reference at the negative limit.
        aif.mod = 8'sh80;
        wait_sync_a(n);
        wait_sync_a(n);
        repeat (129) @(negedge clk);     // p register now 130
        aif.en = 1'b0;
        @(negedge clk);
        check("en_off_gate_next", int'(aif.gate), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("en_off_gate_%0d", i), int'(aif.gate), 0);
            check($sformatf("en_off_sync_%0d", i), int'(aif.sync), 0);
        end
        aif.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("en_on_dead_%0d", i), int'(aif.gate), 0);
        end
        @(negedge clk);
        check("en_on_first_gate", int'(aif.gate), 'h666);
        bad = 0;
        for (int i = 0; i < 480; i++) begin
            @(negedge clk);
            if (aif.gate != 12'h666) bad++;
        end
        check("neg_limit_full_period_bad", bad, 0);

        // Duty table on the single-cell, zero-dead-time instances.
        for (int v = 0; v < 8; v++) begin
            set_bc(tbl[v].mod);
            wait_sync_b(n);
            wait_sync_b(n);
            ca = 0; cb = 0; cc = 0; cd = 0; nc = 0;
            for (int i = 0; i < 480; i++) begin
                @(negedge clk);
                ca += int'(bif.gate[0]);
                cb += int'(bif.gate[2]);
                cc += int'(cif.gate[0]);
                cd += int'(cif.gate[2]);
                if (bif.gate[0] == bif.gate[1]) nc++;
            end
            check($sformatf("b_tr0_count_mod%0d", tbl[v].mod), ca, tbl[v].exp_a);
            check($sformatf("b_tr2_count_mod%0d", tbl[v].mod), cb, tbl[v].exp_b);
            check($sformatf("c_tr0_count_mod%0d", tbl[v].mod), cc, tbl[v].exp_a);
            check($sformatf("c_tr2_count_mod%0d", tbl[v].mod), cd, tbl[v].exp_b);
            check($sformatf("b_tr0_tr1_not_compl_mod%0d", tbl[v].mod), nc, 0);
        end

        // Reference update timing: mod 0->60 at p=100. Window covers carrier
        // phases 100..479 (gate lags p by 2). Peak-only latch keeps 241;
        // peak+trough latch switches after p=240: 121 + 180 = 301.
        set_bc(8'sd0);
        wait_sync_b(n);
        wait_sync_b(n);
        repeat (99) @(negedge clk);      // p register now 100
        set_bc(8'sd60);
        repeat (2) @(negedge clk);       // p register now 102
        ca = 0;
        cc = 0;
        for (int i = 0; i < 380; i++) begin
            if (i > 0) @(negedge clk);
            ca += int'(bif.gate[0]);
            cc += int'(cif.gate[0]);
        end
        check("upd_mode0_window_count", ca, 241);
        check("upd_mode1_window_count", cc, 301);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
